// File: rtl/stack_arbiter.sv
// Two-requester front end for a single shared stack. One push/pop is in flight at a time.
// Push-on-full and pop-on-empty are answered with an error here and never reach the stack.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for a request; winner's req_ready asserted combinationally
//   ISSUE  | one-cycle stack strobe (or error decision), capture pop data
//   RESP   | owner's rsp_valid held with stable data/err until rsp_ready
module stack_arbiter #(
  parameter int WIDTH       = 2,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req_valid,
  input  logic             a_req_op,
  input  logic [WIDTH-1:0] a_req_data,
  output logic             a_req_ready,
  output logic             a_rsp_valid,
  output logic [WIDTH-1:0] a_rsp_data,
  output logic             a_rsp_err,
  input  logic             a_rsp_ready,
  input  logic             b_req_valid,
  input  logic             b_req_op,
  input  logic [WIDTH-1:0] b_req_data,
  output logic             b_req_ready,
  output logic             b_rsp_valid,
  output logic [WIDTH-1:0] b_rsp_data,
  output logic             b_rsp_err,
  input  logic             b_rsp_ready,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_data_in,
  input  logic [WIDTH-1:0] stk_data_out,
  input  logic             stk_full,
  input  logic             stk_empty,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_b_q, last_b_d;
  logic             owner_b_q, owner_b_d;
  logic             op_pop_q, op_pop_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             grant_a, grant_b;

  // last_b_q=1 means B had the most recent grant, so A wins the next tie
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (ROUND_ROBIN) begin
      if (a_req_valid && b_req_valid) begin
        grant_a = last_b_q;
        grant_b = !last_b_q;
      end else begin
        grant_a = a_req_valid;
        grant_b = b_req_valid;
      end
    end else begin
      grant_a = a_req_valid;
      grant_b = !a_req_valid && b_req_valid;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    owner_b_d   = owner_b_q;
    op_pop_d    = op_pop_q;
    data_d      = data_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    a_req_ready = 1'b0;
    b_req_ready = 1'b0;
    a_rsp_valid = 1'b0;
    a_rsp_data  = '0;
    a_rsp_err   = 1'b0;
    b_rsp_valid = 1'b0;
    b_rsp_data  = '0;
    b_rsp_err   = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_data_in = '0;
    busy        = 1'b0;

    // outputs are forced quiet in a reset cycle so the stack is never touched then
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (grant_a || grant_b) begin
            a_req_ready = grant_a;
            b_req_ready = grant_b;
            owner_b_d   = grant_b;
            last_b_d    = grant_b;
            op_pop_d    = grant_b ? b_req_op : a_req_op;
            data_d      = grant_b ? b_req_data : a_req_data;
            state_d     = S_ISSUE;
          end
        end
        S_ISSUE: begin
          busy       = 1'b1;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          if (!op_pop_q) begin
            if (stk_full) begin
              rsp_err_d = 1'b1;
            end else begin
              stk_push    = 1'b1;
              stk_data_in = data_q;
            end
          end else begin
            if (stk_empty) begin
              rsp_err_d = 1'b1;
            end else begin
              stk_pop    = 1'b1;
              rsp_data_d = stk_data_out;
            end
          end
          state_d = S_RESP;
        end
        S_RESP: begin
          busy = 1'b1;
          if (owner_b_q) begin
            b_rsp_valid = 1'b1;
            b_rsp_data  = rsp_data_q;
            b_rsp_err   = rsp_err_q;
            if (b_rsp_ready) state_d = S_IDLE;
          end else begin
            a_rsp_valid = 1'b1;
            a_rsp_data  = rsp_data_q;
            a_rsp_err   = rsp_err_q;
            if (a_rsp_ready) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_b_q   <= 1'b1;
      owner_b_q  <= 1'b0;
      op_pop_q   <= 1'b0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      owner_b_q  <= owner_b_d;
      op_pop_q   <= op_pop_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench for stack_arbiter: a 4-deep stack model sits behind the DUT, expected
// responses come from an abstract stack/arbitration model and are checked by a monitor.
module tb_stack_arbiter;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req_valid, a_req_op, a_req_ready, a_rsp_valid, a_rsp_err, a_rsp_ready;
  logic [1:0] a_req_data, a_rsp_data;
  logic       b_req_valid, b_req_op, b_req_ready, b_rsp_valid, b_rsp_err, b_rsp_ready;
  logic [1:0] b_req_data, b_rsp_data;
  logic       stk_push, stk_pop, stk_full, stk_empty, busy;
  logic [1:0] stk_data_in, stk_data_out;

  // fixed-priority instance, driven separately
  logic       f_a_valid, f_b_valid, f_a_ready, f_b_ready, f_a_rv, f_b_rv, f_a_err, f_b_err;
  logic       f_push, f_pop, f_busy;
  logic [1:0] f_a_rd, f_b_rd, f_din;

  always #5 clk = ~clk;

  stack_arbiter #(.WIDTH(2), .ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_op(a_req_op), .a_req_data(a_req_data),
    .a_req_ready(a_req_ready), .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .a_rsp_err(a_rsp_err), .a_rsp_ready(a_rsp_ready),
    .b_req_valid(b_req_valid), .b_req_op(b_req_op), .b_req_data(b_req_data),
    .b_req_ready(b_req_ready), .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
    .b_rsp_err(b_rsp_err), .b_rsp_ready(b_rsp_ready),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
    .stk_data_out(stk_data_out), .stk_full(stk_full), .stk_empty(stk_empty), .busy(busy)
  );

  stack_arbiter #(.WIDTH(2), .ROUND_ROBIN(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .a_req_valid(f_a_valid), .a_req_op(1'b0), .a_req_data(2'b01),
    .a_req_ready(f_a_ready), .a_rsp_valid(f_a_rv), .a_rsp_data(f_a_rd),
    .a_rsp_err(f_a_err), .a_rsp_ready(1'b1),
    .b_req_valid(f_b_valid), .b_req_op(1'b0), .b_req_data(2'b10),
    .b_req_ready(f_b_ready), .b_rsp_valid(f_b_rv), .b_rsp_data(f_b_rd),
    .b_rsp_err(f_b_err), .b_rsp_ready(1'b1),
    .stk_push(f_push), .stk_pop(f_pop), .stk_data_in(f_din),
    .stk_data_out(2'b00), .stk_full(1'b0), .stk_empty(1'b0), .busy(f_busy)
  );

  // physical stack behind the DUT, moved only by the DUT's strobes
  logic [1:0] mem [DEPTH];
  logic [2:0] cnt = 3'd0;
  always @(posedge clk) begin
    if (stk_push && cnt < 3'(DEPTH)) begin
      mem[cnt[1:0]] <= stk_data_in;
      cnt <= cnt + 3'd1;
    end else if (stk_pop && cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end
  logic [1:0] top_idx;
  assign top_idx      = 2'(cnt - 3'd1);
  assign stk_full     = (cnt == 3'(DEPTH));
  assign stk_empty    = (cnt == 3'd0);
  assign stk_data_out = stk_empty ? 2'b00 : mem[top_idx];

  logic [14:0] out_vec;
  assign out_vec = {a_req_ready, a_rsp_valid, a_rsp_data, a_rsp_err,
                    b_req_ready, b_rsp_valid, b_rsp_data, b_rsp_err,
                    stk_push, stk_pop, stk_data_in, busy};

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // reference model: an unbounded-looking stack capped at DEPTH, plus who-went-last
  typedef struct { logic [1:0] d; logic e; } rsp_t;
  logic [1:0] ref_stk[$];
  rsp_t       exp_a[$], exp_b[$];
  bit         m_last_b = 1'b1;
  bit         rnd_rsp = 1'b0;

  function automatic void model_exec(bit who_b, bit op, logic [1:0] d, bit want_rsp);
    rsp_t r;
    r.d = 2'b00;
    r.e = 1'b0;
    if (!op) begin
      if (ref_stk.size() >= DEPTH) r.e = 1'b1;
      else ref_stk.push_back(d);
    end else begin
      if (ref_stk.size() == 0) r.e = 1'b1;
      else r.d = ref_stk.pop_back();
    end
    m_last_b = who_b;
    if (want_rsp) begin
      if (who_b) exp_b.push_back(r);
      else exp_a.push_back(r);
    end
  endfunction

  function automatic bit exp_winner_b(bit va, bit vb);
    if (va && vb) return !m_last_b;
    return vb && !va;
  endfunction

  // monitor: stack strobe legality and response scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      rsp_t r;
      chk("push_pop_excl", 32'(stk_push & stk_pop), 0);
      chk("din_idle_zero", stk_push ? 32'd0 : 32'(stk_data_in), 0);
      chk("both_rsp_valid", 32'(a_rsp_valid & b_rsp_valid), 0);
      if (stk_push) chk("push_on_full", 32'(stk_full), 0);
      if (stk_pop) chk("pop_on_empty", 32'(stk_empty), 0);
      if (a_rsp_valid && a_rsp_ready) begin
        if (exp_a.size() == 0) chk("a_rsp_unexpected", 32'(a_rsp_valid), 0);
        else begin
          r = exp_a.pop_front();
          chk("a_rsp_data", 32'(a_rsp_data), 32'(r.d));
          chk("a_rsp_err", 32'(a_rsp_err), 32'(r.e));
        end
      end
      if (b_rsp_valid && b_rsp_ready) begin
        if (exp_b.size() == 0) chk("b_rsp_unexpected", 32'(b_rsp_valid), 0);
        else begin
          r = exp_b.pop_front();
          chk("b_rsp_data", 32'(b_rsp_data), 32'(r.d));
          chk("b_rsp_err", 32'(b_rsp_err), 32'(r.e));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rsp) begin
      a_rsp_ready = ($urandom_range(0, 3) != 0);
      b_rsp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // wait for the DUT to accept one of the currently driven requests; ends at posedge+1
  task automatic grant_wait(output bit who_b);
    bit done = 1'b0;
    bit ew;
    who_b = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (a_req_ready || b_req_ready) begin
        ew = exp_winner_b(a_req_valid, b_req_valid);
        chk("single_ready", 32'(a_req_ready & b_req_ready), 0);
        chk("grant_while_busy", 32'(busy), 0);
        chk("winner", 32'(b_req_ready), 32'(ew));
        who_b = b_req_ready;
        model_exec(who_b, who_b ? b_req_op : a_req_op, who_b ? b_req_data : a_req_data, 1'b1);
        done = 1'b1;
      end
      step();
    end
    if (!done) chk("grant_timeout", 0, 1);
  endtask

  task automatic do_one(bit who_b, bit op, logic [1:0] d);
    bit w;
    if (who_b) begin b_req_valid = 1'b1; b_req_op = op; b_req_data = d; end
    else begin a_req_valid = 1'b1; a_req_op = op; a_req_data = d; end
    grant_wait(w);
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 80 && !ok; k++) begin
      @(negedge clk);
      if (!busy && exp_a.size() == 0 && exp_b.size() == 0) ok = 1'b1;
      step();
    end
    chk("idle_timeout", 32'(ok), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit who;
    int ca, cb;
    rst = 1'b1;
    a_req_valid = 0; a_req_op = 0; a_req_data = 0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_op = 0; b_req_data = 0; b_rsp_ready = 0;
    f_a_valid = 0; f_b_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outputs", 32'(out_vec), 0);
    chk("reset_fp_busy", 32'(f_busy), 0);

    // A pushes 2'b10 with cycle-exact timing, then stalls its response
    step();
    rst = 1'b0;
    a_req_valid = 1; a_req_op = 0; a_req_data = 2'b10;
    @(negedge clk);
    chk("t1_a_ready_c0", 32'(a_req_ready), 1);
    model_exec(1'b0, 1'b0, 2'b10, 1'b1);
    step();
    a_req_valid = 0;
    b_req_valid = 1; b_req_op = 1;
    @(negedge clk);
    chk("t1_push_c1", 32'(stk_push), 1);
    chk("t1_din_c1", 32'(stk_data_in), 32'h2);
    chk("t1_b_ready_issue", 32'(b_req_ready), 0);
    step();
    @(negedge clk);
    chk("t1_a_rsp_valid_c2", 32'(a_rsp_valid), 1);
    chk("t1_a_rsp_err_c2", 32'(a_rsp_err), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("stall_valid", 32'(a_rsp_valid), 1);
      chk("stall_data", 32'(a_rsp_data), 0);
      chk("stall_busy", 32'(busy), 1);
      chk("stall_b_ready", 32'(b_req_ready), 0);
    end
    step();
    a_rsp_ready = 1;
    b_rsp_ready = 1;
    @(negedge clk);
    chk("release_valid", 32'(a_rsp_valid), 1);
    step();
    @(negedge clk);
    chk("release_idle", 32'(busy), 0);
    chk("b_pending_granted", 32'(b_req_ready), 1);
    model_exec(1'b1, 1'b1, 2'b00, 1'b1);
    step();
    b_req_valid = 0;
    @(negedge clk);
    chk("t2_pop_strobe", 32'(stk_pop), 1);
    step();
    @(negedge clk);
    chk("t2_b_rsp_data", 32'(b_rsp_data), 32'h2);
    chk("t2_a_rsp_quiet", 32'(a_rsp_valid), 0);
    step();

    // empty pop, fill past full, drain past empty
    do_one(1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 5; i++) do_one(1'b1, 1'b0, 2'($urandom));
    for (int i = 0; i < 5; i++) do_one(1'b0, 1'b1, 2'b00);
    wait_idle();

    // reset while in ISSUE: accepted push must vanish without a strobe
    a_req_valid = 1; a_req_op = 0; a_req_data = 2'b11;
    @(negedge clk);
    chk("abort_issue_ready", 32'(a_req_ready), 1);
    step();
    a_req_valid = 0;
    rst = 1;
    @(negedge clk);
    chk("abort_issue_outputs", 32'(out_vec), 0);
    step();
    rst = 0;
    m_last_b = 1'b1;
    @(negedge clk);
    chk("after_issue_abort", 32'(out_vec), 0);

    // reset while in RESP: stack was written, response is dropped
    a_rsp_ready = 0;
    step();
    a_req_valid = 1; a_req_op = 0; a_req_data = 2'b01;
    @(negedge clk);
    chk("abort_resp_ready", 32'(a_req_ready), 1);
    model_exec(1'b0, 1'b0, 2'b01, 1'b0);
    step();
    a_req_valid = 0;
    step();
    @(negedge clk);
    chk("abort_resp_valid", 32'(a_rsp_valid), 1);
    step();
    rst = 1;
    @(negedge clk);
    chk("abort_resp_outputs", 32'(out_vec), 0);
    step();
    rst = 0;
    m_last_b = 1'b1;
    a_rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_rsp_after_abort", 32'(out_vec), 0);
      step();
    end

    // continuous tie: round-robin A,B,A,B starting with A after reset
    a_req_valid = 1; a_req_op = 0; a_req_data = 2'b11;
    b_req_valid = 1; b_req_op = 0; b_req_data = 2'b00;
    for (int i = 0; i < 4; i++) begin
      grant_wait(who);
      chk("rr_sequence", 32'(who), 32'(i % 2));
    end
    a_req_valid = 0;
    b_req_valid = 0;
    wait_idle();

    // randomized traffic with random response back-pressure
    rnd_rsp = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if (!a_req_valid && $urandom_range(0, 2) != 0) begin
        a_req_valid = 1; a_req_op = 1'($urandom); a_req_data = 2'($urandom);
      end
      if (!b_req_valid && $urandom_range(0, 2) != 0) begin
        b_req_valid = 1; b_req_op = 1'($urandom); b_req_data = 2'($urandom);
      end
      if (!a_req_valid && !b_req_valid) begin
        a_req_valid = 1; a_req_op = 1'($urandom); a_req_data = 2'($urandom);
      end
      grant_wait(who);
      if (who) b_req_valid = 0;
      else a_req_valid = 0;
    end
    rnd_rsp = 1'b0;
    a_req_valid = 0;
    b_req_valid = 0;
    a_rsp_ready = 1;
    b_rsp_ready = 1;
    wait_idle();
    chk("scoreboard_drained", 32'(exp_a.size() + exp_b.size()), 0);

    // fixed priority: A holds every grant while both request
    f_a_valid = 1;
    f_b_valid = 1;
    ca = 0;
    cb = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (f_a_ready) ca++;
      if (f_b_ready) cb++;
    end
    chk("fp_a_grants", 32'(ca), 4);
    chk("fp_b_grants", 32'(cb), 0);
    step();
    f_a_valid = 0;
    f_b_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
